// File: rtl/multicycle_main_controller_pkg.sv
// ----------------------------------------------------------------------------
// controller_pkg
// Shared types and encodings for the multicycle ARM main controller:
//   - state_t        : main FSM state enum
//   - OP_*           : instr[27:26] major opcode classes
//   - CMD_*          : supported data-processing cmd fields (instr[24:21])
//   - ALU_*          : alu_control encodings
//   - SRCB_*, RES_*  : alu_source_b and result_source select values
// ----------------------------------------------------------------------------
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_EXT  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_main_controller_alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
// Combinational decode of the data-processing cmd and S bit.
//   cmd          in  4  instr[24:21]
//   s            in  1  instr[20], set-flags bit
//   alu_control  out 2  ALU operation (ADD when cmd is unsupported)
//   flag_write   out 2  [1] NZ request, [0] CV request (arithmetic ops only)
//   unsupported  out 1  cmd is not one of ADD/SUB/AND/ORR
// The top gates alu_control/flag_write with the execute states.
// ----------------------------------------------------------------------------
module alu_decoder
    import controller_pkg::*;
(
    input  logic [3:0] cmd,
    input  logic       s,
    output logic [1:0] alu_control,
    output logic [1:0] flag_write,
    output logic       unsupported
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_control = ALU_ADD;
        unsupported = 1'b0;
        case (cmd)
            CMD_ADD: alu_control = ALU_ADD;
            CMD_SUB: alu_control = ALU_SUB;
            CMD_AND: alu_control = ALU_AND;
            CMD_ORR: alu_control = ALU_ORR;
            default: unsupported = 1'b1;
        endcase
    end

    // Carry/overflow only mean something for arithmetic results.
    assign flag_write[1] = s & ~unsupported;
    assign flag_write[0] = s & ~unsupported &
                           ((alu_control == ALU_ADD) | (alu_control == ALU_SUB));

endmodule

// File: rtl/multicycle_main_controller.sv
// ----------------------------------------------------------------------------
// multicycle_main_controller
// Main Moore control FSM of the multicycle ARM core. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives datapath selects,
// unconditional strobes and the potential_* requests for the condition logic.
//   clock, reset (async, active-low)
//   op, funct, rd                : latched instruction fields
//   instruction_write, next_pc   : fetch strobes
//   address_source, alu_source_a, alu_source_b, result_source, alu_control
//   potential_register_write/memory_write/flag_write/program_counter, link
// Optional feature macro: BRANCH_LINK_EN (BL writes PC+4 to R14).
// Only the state is registered; all outputs are combinational.
// ----------------------------------------------------------------------------
module multicycle_main_controller
    import controller_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    output logic       instruction_write,
    output logic       next_pc,
    output logic       address_source,
    output logic       alu_source_a,
    output logic [1:0] alu_source_b,
    output logic [1:0] result_source,
    output logic [1:0] alu_control,
    output logic       potential_register_write,
    output logic       potential_memory_write,
    output logic [1:0] potential_flag_write,
    output logic       potential_program_counter,
    output logic       link
);

    state_t     state_q, state_d;
    logic [1:0] dec_alu_control;
    logic [1:0] dec_flag_write;
    logic       dec_unsupported;
    logic       alu_en;
    logic       iw, npc, prw, pmw, ppc, lnk;

    alu_decoder u_alu_decoder (
        .cmd         (funct[4:1]),
        .s           (funct[0]),
        .alu_control (dec_alu_control),
        .flag_write  (dec_flag_write),
        .unsupported (dec_unsupported)
    );

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    OP_DP:   state_d = dec_unsupported ? S_FETCH :
                                       (funct[5] ? S_EXECUTEI : S_EXECUTER);
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER,
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // NOTE: state uses non-blocking assignment with the async reset in the sensitivity list.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        iw             = 1'b0;
        npc            = 1'b0;
        address_source = 1'b0;
        alu_source_a   = 1'b0;
        alu_source_b   = SRCB_REG;
        result_source  = RES_ALUOUT;
        prw            = 1'b0;
        pmw            = 1'b0;
        ppc            = 1'b0;
        lnk            = 1'b0;
        alu_en         = 1'b0;
        case (state_q)
            S_FETCH: begin
                iw            = 1'b1;
                npc           = 1'b1;
                alu_source_a  = 1'b1;
                alu_source_b  = SRCB_FOUR;
                result_source = RES_ALU;
            end
            S_DECODE: begin
                alu_source_a  = 1'b1;
                alu_source_b  = SRCB_FOUR;
                result_source = RES_ALU;
            end
            S_MEMADR:  alu_source_b = SRCB_EXT;
            S_MEMREAD: address_source = 1'b1;
            S_MEMWB: begin
                result_source = RES_DATA;
                prw           = 1'b1;
                ppc           = (rd == 4'hF);
            end
            S_MEMWRITE: begin
                address_source = 1'b1;
                pmw            = 1'b1;
            end
            S_EXECUTER: alu_en = 1'b1;
            S_EXECUTEI: begin
                alu_source_b = SRCB_EXT;
                alu_en       = 1'b1;
            end
            S_ALUWB: begin
                prw = 1'b1;
                ppc = (rd == 4'hF);
            end
            S_BRANCH: begin
                alu_source_b  = SRCB_EXT;
                result_source = RES_ALU;
                ppc           = 1'b1;
`ifdef BRANCH_LINK_EN
                lnk           = funct[4];
                prw           = funct[4];
`else
                lnk           = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    assign alu_control          = alu_en ? dec_alu_control : ALU_ADD;
    assign potential_flag_write = (alu_en && reset) ? dec_flag_write : 2'b00;

    // Strobes are suppressed while reset is held; selects keep their FETCH values.
    assign instruction_write         = iw  & reset;
    assign next_pc                   = npc & reset;
    assign potential_register_write  = prw & reset;
    assign potential_memory_write    = pmw & reset;
    assign potential_program_counter = ppc & reset;
    assign link                      = lnk & reset;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// ----------------------------------------------------------------------------
// tb_multicycle_main_controller
// Directed test of the main controller. All outputs are packed into one
// 16-bit observation word and compared against hand-built per-state values.
// ----------------------------------------------------------------------------
module tb_multicycle_main_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] op    = 2'b00;
    logic [5:0] funct = 6'b000000;
    logic [3:0] rd    = 4'h0;
    logic       instruction_write, next_pc, address_source, alu_source_a;
    logic [1:0] alu_source_b, result_source, alu_control, potential_flag_write;
    logic       potential_register_write, potential_memory_write;
    logic       potential_program_counter, link;

    int checks = 0;
    int errors = 0;

`ifdef BRANCH_LINK_EN
    localparam logic LE = 1'b1;
`else
    localparam logic LE = 1'b0;
`endif

    multicycle_main_controller dut (
        .clock                     (clock),
        .reset                     (reset),
        .op                        (op),
        .funct                     (funct),
        .rd                        (rd),
        .instruction_write         (instruction_write),
        .next_pc                   (next_pc),
        .address_source            (address_source),
        .alu_source_a              (alu_source_a),
        .alu_source_b              (alu_source_b),
        .result_source             (result_source),
        .alu_control               (alu_control),
        .potential_register_write  (potential_register_write),
        .potential_memory_write    (potential_memory_write),
        .potential_flag_write      (potential_flag_write),
        .potential_program_counter (potential_program_counter),
        .link                      (link)
    );

    always #5 clock = ~clock;

    // {iw, npc, as, asa, asb[1:0], rs[1:0], alu[1:0], prw, pmw, pfw[1:0], ppc, link}
    logic [15:0] obs;
    assign obs = {instruction_write, next_pc, address_source, alu_source_a,
                  alu_source_b, result_source, alu_control,
                  potential_register_write, potential_memory_write,
                  potential_flag_write, potential_program_counter, link};

    function automatic logic [15:0] vec(input logic iw, npc, as_, asa,
                                        input logic [1:0] asb, rs, alu,
                                        input logic prw, pmw,
                                        input logic [1:0] pfw,
                                        input logic ppc, lnk);
        return {iw, npc, as_, asa, asb, rs, alu, prw, pmw, pfw, ppc, lnk};
    endfunction

    // Expected words for the fixed-output states
    localparam logic [15:0] E_FETCH  = {1'b1,1'b1,1'b0,1'b1,2'b10,2'b10,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] E_RST    = {1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] E_DECODE = {1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] E_MEMADR = {1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] E_MEMRD  = {1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [15:0] E_MEMWR  = {1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,2'b00,1'b0,1'b0};

    task automatic check(input string tag, input logic [15:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, expected);
        end
    endtask

    // Advance one clock and sample away from the edge
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    initial begin
        // Reset held for 3 cycles
        @(negedge clock);
        check("reset_hold0", E_RST);
        step(); step(); step();
        check("reset_hold3", E_RST);
        reset = 1'b1;
        #1;
        check("first_fetch", E_FETCH);

        // ADD R1,R2,#5 with S
        op = 2'b00; funct = 6'b101001; rd = 4'h1;
        step(); check("add_decode", E_DECODE);
        step(); check("add_executei", vec(0,0,0,0,2'b01,2'b00,2'b00,0,0,2'b11,0,0));
        step(); check("add_aluwb", vec(0,0,0,0,2'b00,2'b00,2'b00,1,0,2'b00,0,0));
        step(); check("add_fetch", E_FETCH);

        // LDR to R15
        op = 2'b01; funct = 6'b011001; rd = 4'hF;
        step(); check("ldr_decode", E_DECODE);
        step(); check("ldr_memadr", E_MEMADR);
        step(); check("ldr_memread", E_MEMRD);
        step(); check("ldr_memwb", vec(0,0,0,0,2'b00,2'b01,2'b00,1,0,2'b00,1,0));
        step(); check("ldr_fetch", E_FETCH);

        // STR
        op = 2'b01; funct = 6'b011000; rd = 4'h2;
        step(); check("str_decode", E_DECODE);
        step(); check("str_memadr", E_MEMADR);
        step(); check("str_memwrite", E_MEMWR);
        step(); check("str_fetch", E_FETCH);

        // AND with S, register operand
        op = 2'b00; funct = 6'b000001; rd = 4'h3;
        step(); check("and_decode", E_DECODE);
        step(); check("and_executer", vec(0,0,0,0,2'b00,2'b00,2'b10,0,0,2'b10,0,0));
        step(); check("and_aluwb", vec(0,0,0,0,2'b00,2'b00,2'b00,1,0,2'b00,0,0));
        step(); check("and_fetch", E_FETCH);

        // Unsupported cmd 1111: two cycles, no writes
        op = 2'b00; funct = 6'b011111; rd = 4'hF;
        step(); check("bad_cmd_decode", E_DECODE);
        step(); check("bad_cmd_fetch", E_FETCH);

        // Illegal op 11
        op = 2'b11; funct = 6'b111111; rd = 4'hF;
        step(); check("illegal_decode", E_DECODE);
        step(); check("illegal_fetch", E_FETCH);

        // SUB, no S, writeback to R15
        op = 2'b00; funct = 6'b000100; rd = 4'hF;
        step(); check("sub_decode", E_DECODE);
        step(); check("sub_executer", vec(0,0,0,0,2'b00,2'b00,2'b01,0,0,2'b00,0,0));
        step(); check("sub_aluwb_r15", vec(0,0,0,0,2'b00,2'b00,2'b00,1,0,2'b00,1,0));
        step(); check("sub_fetch", E_FETCH);

        // ORR immediate with S: NZ only
        op = 2'b00; funct = 6'b111001; rd = 4'h4;
        step(); check("orr_decode", E_DECODE);
        step(); check("orr_executei", vec(0,0,0,0,2'b01,2'b00,2'b11,0,0,2'b10,0,0));
        step(); check("orr_aluwb", vec(0,0,0,0,2'b00,2'b00,2'b00,1,0,2'b00,0,0));
        step(); check("orr_fetch", E_FETCH);

        // BL
        op = 2'b10; funct = 6'b010000; rd = 4'h0;
        step(); check("bl_decode", E_DECODE);
        step(); check("bl_branch", vec(0,0,0,0,2'b01,2'b10,2'b00,LE,0,2'b00,1,LE));
        step(); check("bl_fetch", E_FETCH);

        // Plain B: never links
        op = 2'b10; funct = 6'b000000;
        step(); check("b_decode", E_DECODE);
        step(); check("b_branch", vec(0,0,0,0,2'b01,2'b10,2'b00,0,0,2'b00,1,0));
        step(); check("b_fetch", E_FETCH);

        // BL again, reset asserted mid-BRANCH
        op = 2'b10; funct = 6'b010000;
        step(); check("blr_decode", E_DECODE);
        step(); check("blr_branch", vec(0,0,0,0,2'b01,2'b10,2'b00,LE,0,2'b00,1,LE));
        reset = 1'b0;
        #1;
        check("blr_async_reset", E_RST);
        step();
        check("blr_reset_held", E_RST);
        reset = 1'b1;
        #1;
        check("blr_refetch", E_FETCH);
        step(); check("blr_redecode", E_DECODE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates
    initial begin
        #20000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_main_controller.md
# multicycle_main_controller

Main control state machine for the multicycle ARM core. Decodes the latched instruction fields and steps each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath multiplexer selects and the unconditional strobes. It also produces the `potential_*` write requests that the conditional logic gates with the condition check, so it is the upstream initiator of that interface.

## Interface

Parameters: none.

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `op`  in  2  instr[27:26]; 00 data-processing, 01 memory, 10 branch, 11 illegal
- `funct`  in  6  instr[25:20]; [5] I, [4:1] cmd, [0] S (data-processing) or L (memory); [4] link bit (branch)
- `rd`  in  4  instr[15:12]
- `instruction_write`  out  1  latch fetched word into the instruction register
- `next_pc`  out  1  unconditional PC write (fetch)
- `address_source`  out  1  0 = PC, 1 = ALU result register
- `alu_source_a`  out  1  0 = register A, 1 = PC
- `alu_source_b`  out  2  00 = register B, 01 = extended immediate, 10 = constant 4
- `result_source`  out  2  00 = ALU result register, 01 = data register, 10 = ALU result (combinational)
- `alu_control`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `potential_register_write`  out  1  register write request
- `potential_memory_write`  out  1  memory write request
- `potential_flag_write`  out  2  [1] NZ request, [0] CV request
- `potential_program_counter`  out  1  conditional PC write request (branch, or writeback to R15)
- `link`  out  1  route PC+4 to R14 (BL)

## Operation

- Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR (op 01), EXECUTER (op 00, I=0), EXECUTEI (op 00, I=1), BRANCH (op 10).
  - DECODE→FETCH for op 11, or for op 00 with an unsupported cmd (no write asserted).
  - MEMADR→MEMREAD if L=1, else MEMWRITE.
  - MEMREAD→MEMWB.
  - EXECUTER/EXECUTEI→ALUWB.
  - MEMWB, MEMWRITE, ALUWB, BRANCH→FETCH.
- Per-state outputs; anything not listed is 0:
  - FETCH: instruction_write=1, next_pc=1, alu_source_a=1, alu_source_b=10, result_source=10.
  - DECODE: alu_source_a=1, alu_source_b=10, result_source=10.
  - MEMADR: alu_source_b=01.
  - MEMREAD: address_source=1.
  - MEMWB: result_source=01, potential_register_write=1.
  - MEMWRITE: address_source=1, potential_memory_write=1.
  - EXECUTER: ALU decode enabled.
  - EXECUTEI: alu_source_b=01, ALU decode enabled.
  - ALUWB: potential_register_write=1.
  - BRANCH: alu_source_b=01, result_source=10, potential_program_counter=1.
- potential_program_counter is also 1 in MEMWB or ALUWB when rd==4'hF.
- ALU decode:
  - Applies only in EXECUTER and EXECUTEI; all other states use alu_control=00.
  - cmd mapping: 0100→00, 0010→01, 0000→10, 1100→11; any other cmd is unsupported.
  - When S=1: potential_flag_write[1]=1, and potential_flag_write[0]=1 only for ADD or SUB.
- Instruction latency: loads 5 cycles; stores and ALU ops 4 cycles; branches 3 cycles.

## Timing

- Registered signal: the state register only. All outputs are combinational from the state and the latched instruction fields.
- `op`, `funct` and `rd` must be stable from DECODE until the instruction's last state. The instruction register only updates in FETCH, which guarantees this.
- Reset assertion (async, any cycle, including mid-instruction):
  - State goes to FETCH immediately.
  - instruction_write, next_pc, all `potential_*` outputs and link are forced to 0 while reset is low.
  - Selects take their FETCH values.
- First fetch occurs on the first rising edge after reset deasserts.
- An illegal or unsupported instruction costs 2 cycles (FETCH, DECODE) and has no architectural effect beyond PC+4.

## Configuration

- `BRANCH_LINK_EN` defined:
  - In BRANCH with funct[4]=1, link=1 and potential_register_write=1.
  - The register file writes PC+4 to R14 under the same condition gating as the branch.
- `BRANCH_LINK_EN` undefined: link is tied to 0 and BL executes as B.

## Structure

- Shared package `controller_pkg` holds:
  - the state enum typedef;
  - op encodings;
  - cmd encodings;
  - the alu_control encodings;
  - the alu_source_b and result_source select constants.
- Sub-module `alu_decoder`: combinational cmd/S decode producing alu_control, potential_flag_write and the unsupported-cmd indication. It is instantiated once.

## Test plan

- **Reset:** hold reset low for 3 cycles, then release. During reset all strobes are 0. In the first cycle after release, instruction_write=1 and next_pc=1.
- **ADD R1,R2,#5 with S set (op=00, funct=101001, rd=1):** state sequence FETCH, DECODE, EXECUTEI, ALUWB, FETCH. In EXECUTEI, alu_control=00, alu_source_b=01, potential_flag_write=11. In ALUWB, potential_register_write=1 and potential_program_counter=0.
- **LDR to R15 (op=01, funct=011001, rd=F):** sequence is 5 states. In MEMREAD, address_source=1. In MEMWB, result_source=01, potential_register_write=1 and potential_program_counter=1.
- **STR (funct[0]=0):** MEMWRITE has potential_memory_write=1 and address_source=1; the next state is FETCH.
- **AND with S set (op=00, funct=000001):** in EXECUTER, alu_control=10 and potential_flag_write=10. Also test cmd=1111: DECODE→FETCH with no write asserted.
- **BL (op=10, funct[4]=1):** in BRANCH, potential_program_counter=1. link=1 and potential_register_write=1 only with `BRANCH_LINK_EN`. Also assert reset mid-BRANCH and check that the state is FETCH asynchronously with strobes at 0.
